vend_ctrl: RTL and testbench



---
 rtl/vend_ctrl.sv | 156 +++++++++++++++
 tb/tb_vend_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/vend_ctrl.sv
// Vending transaction controller: item select, coin accumulation, vend/refund, DONE hold.
// Optional buzzer request is compiled in when VEND_BEEP_EN is defined.
module vend_ctrl #(
  parameter int PRICE_0     = 3,
  parameter int PRICE_1     = 5,
  parameter int PRICE_2     = 8,
  parameter int PRICE_3     = 12,
  parameter int HOLD_CYCLES = 150_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_item,
  input  logic       coin_1,
  input  logic       coin_5,
  input  logic       key_cancel,
  output logic [6:0] price_put,
  output logic [6:0] price_need,
  output logic [6:0] price_out,
  output logic       vend,
  output logic       reject,
  output logic       beep_req,
  output logic       busy
);

  // state | meaning
  // IDLE  | waiting for item selection or first coin
  // PAY   | accumulating coins toward price_need
  // DONE  | showing result (change or refund) for HOLD_CYCLES clocks
  typedef enum logic [1:0] {S_IDLE, S_PAY, S_DONE} state_t;

  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

  state_t        state, state_nx;
  logic [1:0]    item, item_nx;
  logic [CW-1:0] hold_cnt, hold_cnt_nx;
  logic [6:0]    put_nx, out_nx, sel_price;
  logic          vend_nx, reject_nx;
  logic [2:0]    coin_sum;
  logic [7:0]    next_put;

  function automatic logic [6:0] price_of(input logic [1:0] idx);
    case (idx)
      2'd0:    return 7'(PRICE_0);
      2'd1:    return 7'(PRICE_1);
      2'd2:    return 7'(PRICE_2);
      default: return 7'(PRICE_3);
    endcase
  endfunction

  always_comb begin
    coin_sum    = {2'b00, coin_1} + (coin_5 ? 3'd5 : 3'd0);
    next_put    = {1'b0, price_put} + {5'b0, coin_sum};
    state_nx    = state;
    item_nx     = item;
    hold_cnt_nx = hold_cnt;
    put_nx      = price_put;
    out_nx      = price_out;
    vend_nx     = 1'b0;
    reject_nx   = 1'b0;
    sel_price   = price_need;
    case (state)
      S_IDLE: begin
        if (key_item) item_nx = item + 2'd1;
        // a coin arriving with key_item is judged against the newly selected price
        sel_price = price_of(item_nx);
        if (coin_sum != 3'd0) begin
          put_nx = {4'b0, coin_sum};
          if ({4'b0, coin_sum} >= sel_price) begin
            out_nx      = {4'b0, coin_sum} - sel_price;
            vend_nx     = 1'b1;
            hold_cnt_nx = '0;
            state_nx    = S_DONE;
          end else begin
            state_nx = S_PAY;
          end
        end
      end
      S_PAY: begin
        if (key_cancel) begin
          out_nx      = price_put;
          hold_cnt_nx = '0;
          state_nx    = S_DONE;
        end else if (coin_sum != 3'd0) begin
          if (next_put > 8'd99) begin
            reject_nx = 1'b1;
          end else begin
            put_nx = next_put[6:0];
            if (next_put >= {1'b0, price_need}) begin
              out_nx      = next_put[6:0] - price_need;
              vend_nx     = 1'b1;
              hold_cnt_nx = '0;
              state_nx    = S_DONE;
            end
          end
        end
      end
      S_DONE: begin
        if (hold_cnt == HOLD_LAST) begin
          put_nx      = 7'd0;
          out_nx      = 7'd0;
          hold_cnt_nx = '0;
          state_nx    = S_IDLE;
        end else begin
          hold_cnt_nx = hold_cnt + 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      item       <= 2'd0;
      hold_cnt   <= '0;
      price_put  <= 7'd0;
      price_out  <= 7'd0;
      price_need <= 7'(PRICE_0);
      vend       <= 1'b0;
      reject     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nx;
      item       <= item_nx;
      hold_cnt   <= hold_cnt_nx;
      price_put  <= put_nx;
      price_out  <= out_nx;
      price_need <= price_of(item_nx);
      vend       <= vend_nx;
      reject     <= reject_nx;
      busy       <= (state_nx != S_IDLE);
    end
  end

`ifdef VEND_BEEP_EN
  logic beep_nx;

  // accepted coin, vend and cancel collapse into one pulse; vend implies an accepted coin
  always_comb begin
    beep_nx = 1'b0;
    if (state == S_IDLE)
      beep_nx = (coin_sum != 3'd0);
    else if (state == S_PAY)
      beep_nx = key_cancel || ((coin_sum != 3'd0) && (next_put <= 8'd99));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) beep_req <= 1'b0;
    else        beep_req <= beep_nx;
  end
`else
  assign beep_req = 1'b0;
`endif

endmodule

// File: tb/tb_vend_ctrl.sv
// Self-checking bench for vend_ctrl: two instances (PRICE_3 = 12 and 99) driven in lockstep
// and compared every cycle against a transaction-level model, plus directed spot checks.
module tb_vend_ctrl;

  localparam int HOLD = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key_item = 1'b0, coin_1 = 1'b0, coin_5 = 1'b0, key_cancel = 1'b0;

  logic [6:0] put [2];
  logic [6:0] need[2];
  logic [6:0] pout[2];
  logic       vend[2], rej[2], beep[2], busy[2];

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  vend_ctrl #(.PRICE_3(12), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .key_item(key_item), .coin_1(coin_1), .coin_5(coin_5),
    .key_cancel(key_cancel), .price_put(put[0]), .price_need(need[0]), .price_out(pout[0]),
    .vend(vend[0]), .reject(rej[0]), .beep_req(beep[0]), .busy(busy[0]));

  vend_ctrl #(.PRICE_3(99), .HOLD_CYCLES(HOLD)) dut99 (
    .clk(clk), .rst_n(rst_n), .key_item(key_item), .coin_1(coin_1), .coin_5(coin_5),
    .key_cancel(key_cancel), .price_put(put[1]), .price_need(need[1]), .price_out(pout[1]),
    .vend(vend[1]), .reject(rej[1]), .beep_req(beep[1]), .busy(busy[1]));

  // transaction-level reference: phase 0 idle, 1 paying, 2 showing result
  int prc[2][4] = '{'{3, 5, 8, 12}, '{3, 5, 8, 99}};
  int m_item[2], m_put[2], m_out[2], m_phase[2], m_left[2];
  int m_vend[2], m_rej[2], m_beep[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_item[i] = 0; m_put[i] = 0; m_out[i] = 0; m_phase[i] = 0; m_left[i] = 0;
      m_vend[i] = 0; m_rej[i] = 0; m_beep[i] = 0;
    end
  endtask

  task automatic model_step(input int i, input bit ki, input bit c1, input bit c5, input bit kc);
    int sum;
    sum = (c1 ? 1 : 0) + (c5 ? 5 : 0);
    m_vend[i] = 0; m_rej[i] = 0; m_beep[i] = 0;
    if (m_phase[i] == 0) begin
      if (ki) m_item[i] = (m_item[i] + 1) % 4;
      if (sum > 0) begin
        m_put[i] = sum; m_beep[i] = 1;
        if (sum >= prc[i][m_item[i]]) begin
          m_out[i] = sum - prc[i][m_item[i]]; m_vend[i] = 1; m_phase[i] = 2; m_left[i] = HOLD;
        end else m_phase[i] = 1;
      end
    end else if (m_phase[i] == 1) begin
      if (kc) begin
        m_out[i] = m_put[i]; m_beep[i] = 1; m_phase[i] = 2; m_left[i] = HOLD;
      end else if (sum > 0) begin
        if (m_put[i] + sum > 99) m_rej[i] = 1;
        else begin
          m_put[i] += sum; m_beep[i] = 1;
          if (m_put[i] >= prc[i][m_item[i]]) begin
            m_out[i] = m_put[i] - prc[i][m_item[i]]; m_vend[i] = 1; m_phase[i] = 2; m_left[i] = HOLD;
          end
        end
      end
    end else begin
      m_left[i]--;
      if (m_left[i] == 0) begin
        m_put[i] = 0; m_out[i] = 0; m_phase[i] = 0;
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("put%0d", i),    32'(put[i]),  32'(m_put[i]));
      chk($sformatf("need%0d", i),   32'(need[i]), 32'(prc[i][m_item[i]]));
      chk($sformatf("out%0d", i),    32'(pout[i]), 32'(m_out[i]));
      chk($sformatf("vend%0d", i),   32'(vend[i]), 32'(m_vend[i]));
      chk($sformatf("reject%0d", i), 32'(rej[i]),  32'(m_rej[i]));
      chk($sformatf("busy%0d", i),   32'(busy[i]), 32'(m_phase[i] != 0));
`ifdef VEND_BEEP_EN
      chk($sformatf("beep%0d", i),   32'(beep[i]), 32'(m_beep[i]));
`else
      chk($sformatf("beep%0d", i),   32'(beep[i]), 32'd0);
`endif
    end
  endtask

  task automatic step(input bit ki, input bit c1, input bit c5, input bit kc);
    @(negedge clk);
    key_item = ki; coin_1 = c1; coin_5 = c5; key_cancel = kc;
    @(posedge clk);
    model_step(0, ki, c1, c5, kc);
    model_step(1, ki, c1, c5, kc);
    #1;
    compare_all();
    key_item = 1'b0; coin_1 = 1'b0; coin_5 = 1'b0; key_cancel = 1'b0;
  endtask

  task automatic idle_steps(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_vals(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_put"},  32'(put[i]),  32'd0);
      chk({tag, "_need"}, 32'(need[i]), 32'd3);
      chk({tag, "_out"},  32'(pout[i]), 32'd0);
      chk({tag, "_flags"}, 32'({vend[i], rej[i], beep[i], busy[i]}), 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    #12;
    check_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // item cycling
    step(1, 0, 0, 0); chk("cyc_need5",  32'(need[0]), 32'd5);
    step(1, 0, 0, 0); chk("cyc_need8",  32'(need[0]), 32'd8);
    step(1, 0, 0, 0); chk("cyc_need12", 32'(need[0]), 32'd12);
    chk("cyc_need99", 32'(need[1]), 32'd99);
    step(1, 0, 0, 0); chk("cyc_need3",  32'(need[0]), 32'd3);

    // exact pay on item 1
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    chk("exact_put", 32'(put[0]), 32'd5);
    chk("exact_out", 32'(pout[0]), 32'd0);
    chk("exact_vend", 32'(vend[0]), 32'd1);
    chk("exact_busy", 32'(busy[0]), 32'd1);
    idle_steps(1);
    chk("exact_vend_once", 32'(vend[0]), 32'd0);
    idle_steps(3);
    chk("exact_idle_put", 32'(put[0]), 32'd0);
    chk("exact_idle_busy", 32'(busy[0]), 32'd0);

    // dual coin overpay on item 0
    step(1, 0, 0, 0); step(1, 0, 0, 0); step(1, 0, 0, 0);
    step(0, 1, 1, 0);
    chk("dual_put", 32'(put[0]), 32'd6);
    chk("dual_out", 32'(pout[0]), 32'd3);
    chk("dual_vend", 32'(vend[0]), 32'd1);
    idle_steps(HOLD);

    // cancel on item 3, coincident coin discarded
    step(1, 0, 0, 0); step(1, 0, 0, 0); step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    chk("cancel_pay_busy", 32'(busy[0]), 32'd1);
    step(1, 1, 0, 0);
    chk("pay_item_ignored", 32'(need[0]), 32'd12);
    step(0, 0, 1, 1);
    chk("cancel_put", 32'(put[0]), 32'd6);
    chk("cancel_out", 32'(pout[0]), 32'd6);
    chk("cancel_vend", 32'(vend[0]), 32'd0);
    chk("cancel_reject", 32'(rej[0]), 32'd0);
    idle_steps(HOLD - 1);
    chk("cancel_hold_busy", 32'(busy[0]), 32'd1);
    chk("cancel_hold_out", 32'(pout[0]), 32'd6);
    idle_steps(1);
    chk("cancel_done_busy", 32'(busy[0]), 32'd0);

    // overflow refusal against the 99-unit item
    for (int k = 0; k < 19; k++) step(0, 0, 1, 0);
    chk("ovf_put95", 32'(put[1]), 32'd95);
    step(0, 0, 1, 0);
    chk("ovf_reject", 32'(rej[1]), 32'd1);
    chk("ovf_put_held", 32'(put[1]), 32'd95);
    for (int k = 0; k < 4; k++) step(0, 1, 0, 0);
    chk("ovf_put99", 32'(put[1]), 32'd99);
    chk("ovf_vend", 32'(vend[1]), 32'd1);
    chk("ovf_out", 32'(pout[1]), 32'd0);
    idle_steps(HOLD + 2);

    // asynchronous reset in the middle of PAY
    step(0, 1, 0, 0);
    chk("mid_pay_busy", 32'(busy[0]), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 4) == 0, $urandom_range(0, 14) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
